// File: rtl/msk_serial_loader.sv
// ============================================================================
// msk_serial_loader
// ----------------------------------------------------------------------------
// Upstream feeder for the masked state registers. One masked word (d shares
// of count bits, share-interleaved) is accepted per in_valid/in_ready
// handshake. Each accepted word goes into the next slot of a words-deep
// state. When the last slot is written, the complete masked state is shown
// on out_data with out_valid. It stays there, bit-stable, until downstream
// takes it with out_ready.
//
// The datapath only routes and holds bits. Shares are never combined,
// XORed or reordered. The only muxing is the slot select, and the slot
// select depends on the public word counter, never on share values.
//
// Ports
//   clk        in   1                clock, all state updates on posedge
//   rst        in   1                synchronous reset, active-high
//   in_valid   in   1                in_data holds a valid masked word
//   in_ready   out  1                loader accepts a word this cycle (registered)
//   in_data    in   count*d          masked word, bit i of share j at i*d+j
//   out_valid  out  1                out_data holds a complete masked state (registered)
//   out_ready  in   1                downstream consumes out_data this cycle
//   out_data   out  words*count*d    assembled state, word k at slot k
// ============================================================================
module msk_serial_loader #(
    parameter int d     = 2,   // number of shares
    parameter int count = 8,   // bits per masked word
    parameter int words = 16   // words per assembled state
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [count*d-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [words*count*d-1:0]   out_data
);

    localparam int WORD_W = count * d;
    localparam int CNT_W  = (words > 1) ? $clog2(words) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(words - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        FILL = 1'b0,   // collecting words, in_ready=1
        FULL = 1'b1    // holding the complete state, out_valid=1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  slot_q [words];
    logic [WORD_W-1:0]  slot_d [words];

    logic               in_fire;
    logic               out_fire;
    logic               last_word;

    // Handshakes use only the registered ready/valid. Because of that there
    // is no combinational path from in_* to out_*, or from out_ready to
    // in_ready.
    assign in_fire   = in_valid  & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign last_word = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // State register (control only)
    // ------------------------------------------------------------------
    // NOTE: every flop is written with <= so all registers sample the values
    // from before the edge. A blocking '=' here would make the result depend
    // on the order of the statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before the
    // case. If some path left a signal unassigned, synthesis would infer a
    // latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (last_word) begin
                        // The final word completes the state. The counter
                        // wraps here so that the next block starts at slot 0.
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            FULL: begin
                // The FSM only leaves FULL here. The refill starts one cycle
                // later, so there is no bypass from in_data to out_data.
                if (out_fire) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // The handshake outputs are decoded from the next state and then
    // registered. As a result they change on the same edge as the FSM: the
    // last accept raises out_valid with no extra cycle. During rst the
    // register branch holds both outputs low.
    always_comb begin
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == FULL);
    end

    // ------------------------------------------------------------------
    // Share storage
    // ------------------------------------------------------------------
    // Only the slot that the counter points to can load a new word. In FULL,
    // in_ready_q is low, so in_fire is low and every slot keeps its value.
    always_comb begin
        for (int k = 0; k < words; k++) begin
            slot_d[k] = slot_q[k];
            if (in_fire && (cnt_q == CNT_W'(k))) begin
                slot_d[k] = in_data;
            end
        end
    end

    // NOTE: the masked storage has no reset. Clearing it would add a
    // share-dependent reset path and gives no benefit: a stored state is
    // only used after all of its slots have been overwritten.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    for (genvar k = 0; k < words; k++) begin : g_out_slot
        assign out_data[k*WORD_W +: WORD_W] = slot_q[k];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_msk_serial_loader.sv
// Testbench for msk_serial_loader.
// Instance a: default parameters (d=2, count=8, words=16).
// Instance b: parameter sweep (d=3, count=4, words=4).
// Each fill pushes the expected masked state and its recombined plaintext
// into a queue. The monitor pops and compares them on every out handshake.
module tb_msk_serial_loader;

    localparam int A_D = 2, A_C = 8, A_N = 16, A_W = A_D * A_C;
    localparam int B_D = 3, B_C = 4, B_N = 4,  B_W = B_D * B_C;

    typedef logic [511:0] vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;

    logic               a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [A_W-1:0]     a_in_data = '0;
    logic [A_N*A_W-1:0] a_out_data;

    logic               b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [B_W-1:0]     b_in_data = '0;
    logic [B_N*B_W-1:0] b_out_data;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    vec_t a_exp_q[$], a_plain_q[$], b_exp_q[$], b_plain_q[$];
    int   a_hs_cyc[$];
    vec_t a_last_exp, a_basic_exp, b_last_exp;
    logic [7:0] a_masks [A_N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    msk_serial_loader #(.d(A_D), .count(A_C), .words(A_N)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    msk_serial_loader #(.d(B_D), .count(B_C), .words(B_N)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Interleave up to three shares: bit i of share j goes to position i*dd+j.
    function automatic logic [31:0] ilv(input logic [7:0] s0, input logic [7:0] s1,
                                        input logic [7:0] s2, input int dd, input int cc);
        logic [31:0] w = '0;
        for (int i = 0; i < cc; i++)
            for (int j = 0; j < dd; j++)
                w[i*dd+j] = (j == 0) ? s0[i] : ((j == 1) ? s1[i] : s2[i]);
        return w;
    endfunction

    // XOR all shares of one slot back into its plaintext.
    function automatic logic [7:0] recomb(input vec_t v, input int base, input int dd, input int cc);
        logic [7:0] r = '0;
        for (int i = 0; i < cc; i++) begin
            logic b = 1'b0;
            for (int j = 0; j < dd; j++) b = b ^ v[base + i*dd + j];
            r[i] = b;
        end
        return r;
    endfunction

    // ---------------- scoreboard monitors ----------------
    vec_t am_e, am_p, am_r, bm_e, bm_p, bm_r;

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            a_hs_cyc.push_back(cyc);
            if (a_exp_q.size() == 0) begin
                check("a_unexpected_out", 1, 0);
            end else begin
                am_e = a_exp_q.pop_front();
                am_p = a_plain_q.pop_front();
                am_r = '0;
                for (int k = 0; k < A_N; k++) am_r[k*8 +: 8] = recomb(vec_t'(a_out_data), k*A_W, A_D, A_C);
                check("a_out_data", vec_t'(a_out_data), am_e);
                check("a_recomb", am_r, am_p);
            end
            @(posedge clk); #1;
            check("a_in_ready_after_hs", vec_t'(a_in_ready), 1);
            check("a_out_valid_after_hs", vec_t'(a_out_valid), 0);
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected_out", 1, 0);
            end else begin
                bm_e = b_exp_q.pop_front();
                bm_p = b_plain_q.pop_front();
                bm_r = '0;
                for (int k = 0; k < B_N; k++) bm_r[k*4 +: 4] = recomb(vec_t'(b_out_data), k*B_W, B_D, B_C)[3:0];
                check("b_out_data", vec_t'(b_out_data), bm_e);
                check("b_recomb", bm_r, bm_p);
            end
            @(posedge clk); #1;
            check("b_in_ready_after_hs", vec_t'(b_in_ready), 1);
            check("b_out_valid_after_hs", vec_t'(b_out_valid), 0);
        end
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [A_W-1:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            a_in_valid = 1'b0;
            a_in_data  = A_W'($urandom);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b1;
        a_in_data  = w;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                @(posedge clk); #1;
                a_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("a_accept_timeout", 0, 1);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [B_W-1:0] w);
        b_in_valid = 1'b1;
        b_in_data  = w;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (b_in_ready) begin
                @(posedge clk); #1;
                b_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("b_accept_timeout", 0, 1);
        b_in_valid = 1'b0;
    endtask

    // Fill one block on instance a. add_mode selects plain = base+k instead
    // of base^k. reuse_masks replays the masks of the previous fill.
    task automatic fill_a(input logic [7:0] base, input bit add_mode,
                          input bit reuse_masks, input int max_gap);
        vec_t e = '0, p = '0;
        logic [7:0]  m, plain;
        logic [31:0] wf;
        for (int k = 0; k < A_N; k++) begin
            m = reuse_masks ? a_masks[k] : 8'($urandom);
            a_masks[k] = m;
            plain = add_mode ? 8'(base + 8'(k)) : (base ^ 8'(k));
            wf = ilv(plain ^ m, m, 8'h00, A_D, A_C);
            e[k*A_W +: A_W] = wf[A_W-1:0];
            p[k*8 +: 8]     = plain;
            send_a(wf[A_W-1:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        a_exp_q.push_back(e);
        a_plain_q.push_back(p);
        a_last_exp = e;
        check("a_out_valid_after_fill", vec_t'(a_out_valid), 1);
        check("a_in_ready_after_fill", vec_t'(a_in_ready), 0);
    endtask

    task automatic fill_b(input logic [3:0] base);
        vec_t e = '0, p = '0;
        logic [3:0]  m1, m2, plain;
        logic [31:0] wf;
        for (int k = 0; k < B_N; k++) begin
            m1 = 4'($urandom);
            m2 = 4'($urandom);
            plain = base ^ 4'(k);
            wf = ilv({4'h0, plain ^ m1 ^ m2}, {4'h0, m1}, {4'h0, m2}, B_D, B_C);
            e[k*B_W +: B_W] = wf[B_W-1:0];
            p[k*4 +: 4]     = plain;
            send_b(wf[B_W-1:0]);
        end
        b_exp_q.push_back(e);
        b_plain_q.push_back(p);
        b_last_exp = e;
        check("b_out_valid_after_fill", vec_t'(b_out_valid), 1);
        check("b_in_ready_after_fill", vec_t'(b_in_ready), 0);
    endtask

    task automatic pulse_a_ready();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_b_ready();
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_in_ready_rst", vec_t'(a_in_ready), 0);
        check("a_out_valid_rst", vec_t'(a_out_valid), 0);
        check("b_in_ready_rst", vec_t'(b_in_ready), 0);
        check("b_out_valid_rst", vec_t'(b_out_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("a_in_ready_first_edge", vec_t'(a_in_ready), 1);
        check("b_in_ready_first_edge", vec_t'(b_in_ready), 1);

        // Basic fill
        fill_a(8'hA5, 1'b0, 1'b0, 0);
        a_basic_exp = a_last_exp;

        // Backpressure: toggle the input side while FULL
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'($urandom);
            a_in_data  = A_W'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", vec_t'(a_out_valid), 1);
            check("bp_in_ready", vec_t'(a_in_ready), 0);
            check("bp_out_data", vec_t'(a_out_data), a_last_exp);
        end
        a_in_valid = 1'b0;
        pulse_a_ready();

        // Input gaps, same data and masks as the gap-free run
        fill_a(8'hA5, 1'b0, 1'b1, 3);
        check("gap_equals_gapfree", vec_t'(a_out_data), a_basic_exp);
        pulse_a_ready();

        // Reset mid-fill
        for (int k = 0; k < 7; k++) send_a(A_W'($urandom), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("a_in_ready_during_rst", vec_t'(a_in_ready), 0);
        check("a_out_valid_during_rst", vec_t'(a_out_valid), 0);
        rst = 1'b0;
        fill_a(8'h30, 1'b1, 1'b0, 0);
        pulse_a_ready();

        // Streaming: out_ready held high, input continuously valid
        a_hs_cyc.delete();
        a_out_ready = 1'b1;
        for (int blk = 0; blk < 3; blk++) fill_a(8'h5A ^ 8'(blk * 17), 1'b0, 1'b0, 0);
        for (int t = 0; t < 100 && a_hs_cyc.size() < 3; t++) begin
            @(posedge clk); #1;
        end
        a_out_ready = 1'b0;
        if (a_hs_cyc.size() < 3) begin
            check("stream_hs_timeout", vec_t'(a_hs_cyc.size()), 3);
        end else begin
            check("stream_period_1", vec_t'(a_hs_cyc[1] - a_hs_cyc[0]), 17);
            check("stream_period_2", vec_t'(a_hs_cyc[2] - a_hs_cyc[1]), 17);
        end
        repeat (2) @(posedge clk);
        #1;

        // Parameter sweep: two blocks, the second only lands right if the
        // counter wrapped 3 -> 0
        fill_b(4'hA);
        pulse_b_ready();
        fill_b(4'h3);
        check("b_wrap_slot0", vec_t'(b_out_data[B_W-1:0]), vec_t'(b_last_exp[B_W-1:0]));
        pulse_b_ready();

        repeat (3) @(posedge clk);
        #1;
        check("a_sb_drained", vec_t'(a_exp_q.size()), 0);
        check("b_sb_drained", vec_t'(b_exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
